// File: rtl/reg_wb_arbiter_if.sv
// Register-file write-side bus: ALU/mem result inputs, write port, bypass.
// master drives results and read addresses; slave is the arbiter.
interface reg_wb_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              alu_valid;
    logic [ADDR_W-1:0] alu_addr;
    logic [DATA_W-1:0] alu_data;
    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              write_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic              byp_hit1;
    logic              byp_hit2;
    logic [DATA_W-1:0] byp_data1;
    logic [DATA_W-1:0] byp_data2;
    logic [CNT_W-1:0]  pending_cnt;

    modport master (
        output alu_valid, alu_addr, alu_data,
        output mem_valid, mem_addr, mem_data,
        output rd_addr1, rd_addr2,
        input  mem_ready, write_en, wr_addr, wr_data,
        input  byp_hit1, byp_hit2, byp_data1, byp_data2,
        input  pending_cnt
    );

    modport slave (
        input  alu_valid, alu_addr, alu_data,
        input  mem_valid, mem_addr, mem_data,
        input  rd_addr1, rd_addr2,
        output mem_ready, write_en, wr_addr, wr_data,
        output byp_hit1, byp_hit2, byp_data1, byp_data2,
        output pending_cnt
    );
endinterface

// File: rtl/reg_wb_arbiter.sv
// Merges ALU and mem/mul-div results onto the single register-file write
// port, buffering mem results, squashing stale writes and providing bypass.
module reg_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4
) (
    input logic             clk,
    input logic             reset,
    reg_wb_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] q_addr [DEPTH];
    logic [DATA_W-1:0] q_data [DEPTH];
    logic [DEPTH-1:0]  q_valid;
    logic [DEPTH-1:0]  q_valid_nxt;
    logic [PTR_W:0]    wptr;
    logic [PTR_W:0]    rptr;
    logic [PTR_W:0]    used;
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic              empty;
    logic              full;
    logic              head_valid;
    logic              head_skip;
    logic [CNT_W-1:0]  cnt;

    logic              mem_ready;
    logic              mem_live;
    logic              alu_go;

    logic              issue;
    logic [ADDR_W-1:0] iss_addr;
    logic [DATA_W-1:0] iss_data;
    logic              push;
    logic              pop;
    logic [DEPTH-1:0]  squash;

    logic              write_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    assign used       = wptr - rptr;
    assign head       = rptr[PTR_W-1:0];
    assign tail       = wptr[PTR_W-1:0];
    assign empty      = (wptr == rptr);
    // full counts squashed slots too; they still occupy the ring
    assign full       = (used == CNT_W'(DEPTH));
    assign head_valid = !empty && q_valid[head];
    assign head_skip  = !empty && !q_valid[head];

    assign mem_ready = reset & ~full;
    assign mem_live  = bus.mem_valid & mem_ready & (bus.mem_addr != '0);
    assign alu_go    = bus.alu_valid & (bus.alu_addr != '0);

    // Count live (unsquashed) FIFO entries
    always_comb begin
        cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt = cnt + CNT_W'(q_valid[i]);
        end
    end

    // Issue selection: ALU first, then FIFO head, then direct mem result
    always_comb begin
        issue    = 1'b0;
        iss_addr = '0;
        iss_data = '0;
        push     = 1'b0;
        pop      = 1'b0;
        squash   = '0;
        if (alu_go) begin
            issue    = 1'b1;
            iss_addr = bus.alu_addr;
            iss_data = bus.alu_data;
            // ALU is younger than every pending mem result
            push     = mem_live && (bus.mem_addr != bus.alu_addr);
            pop      = head_skip;
            for (int i = 0; i < DEPTH; i++) begin
                squash[i] = q_valid[i] && (q_addr[i] == bus.alu_addr);
            end
        end else if (head_valid) begin
            issue    = 1'b1;
            iss_addr = q_addr[head];
            iss_data = q_data[head];
            push     = mem_live;
            pop      = 1'b1;
        end else if (mem_live && cnt == '0) begin
            issue    = 1'b1;
            iss_addr = bus.mem_addr;
            iss_data = bus.mem_data;
            pop      = head_skip;
        end else begin
            // live entries behind a squashed head keep the new result queued
            push     = mem_live;
            pop      = head_skip;
        end
    end

    // Next valid mask: squash, retire head, mark new tail
    always_comb begin
        q_valid_nxt = q_valid & ~squash;
        if (pop) begin
            q_valid_nxt[head] = 1'b0;
        end
        if (push) begin
            q_valid_nxt[tail] = 1'b1;
        end
    end

    // FIFO pointers and valid bits
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr    <= '0;
            rptr    <= '0;
            q_valid <= '0;
        end else begin
            q_valid <= q_valid_nxt;
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    // FIFO payload; qualified by q_valid so it needs no reset
    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[tail] <= bus.mem_addr;
            q_data[tail] <= bus.mem_data;
        end
    end

    // Registered write port; address/data hold when idle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            write_en <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            write_en <= issue;
            if (issue) begin
                wr_addr <= iss_addr;
                wr_data <= iss_data;
            end
        end
    end

    logic [PTR_W-1:0] idx;
    logic             hit1;
    logic             hit2;
    logic [DATA_W-1:0] bdat1;
    logic [DATA_W-1:0] bdat2;

    // Bypass: output stage first, then FIFO oldest->newest so newest wins
    always_comb begin
        idx   = '0;
        hit1  = 1'b0;
        hit2  = 1'b0;
        bdat1 = '0;
        bdat2 = '0;
        if (bus.rd_addr1 != '0 && write_en && wr_addr == bus.rd_addr1) begin
            hit1  = 1'b1;
            bdat1 = wr_data;
        end
        if (bus.rd_addr2 != '0 && write_en && wr_addr == bus.rd_addr2) begin
            hit2  = 1'b1;
            bdat2 = wr_data;
        end
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if (bus.rd_addr1 != '0 && q_valid[idx] &&
                q_addr[idx] == bus.rd_addr1) begin
                hit1  = 1'b1;
                bdat1 = q_data[idx];
            end
            if (bus.rd_addr2 != '0 && q_valid[idx] &&
                q_addr[idx] == bus.rd_addr2) begin
                hit2  = 1'b1;
                bdat2 = q_data[idx];
            end
        end
    end

    assign bus.mem_ready   = mem_ready;
    assign bus.write_en    = write_en;
    assign bus.wr_addr     = wr_addr;
    assign bus.wr_data     = wr_data;
    assign bus.byp_hit1    = hit1;
    assign bus.byp_hit2    = hit2;
    assign bus.byp_data1   = bdat1;
    assign bus.byp_data2   = bdat2;
    assign bus.pending_cnt = cnt;
endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed vector bench for reg_wb_arbiter.
// Vectors carry state from one to the next, starting from reset.
module tb_reg_wb_arbiter;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    reg_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5), .DEPTH(4)) bus ();

    reg_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .DEPTH(4)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        mv;
        logic [4:0]  ma;
        logic [31:0] md;
        logic [4:0]  rd;
        logic        rdy;
        logic        hit;
        logic [31:0] bd;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        int          cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic av, input logic [4:0] aa, input logic [31:0] ad,
        input logic mv, input logic [4:0] ma, input logic [31:0] md,
        input logic [4:0] rd, input logic rdy, input logic hit,
        input logic [31:0] bd, input logic we, input logic [4:0] wa,
        input logic [31:0] wd, input int cnt);
        vec_t x;
        x.av = av; x.aa = aa; x.ad = ad;
        x.mv = mv; x.ma = ma; x.md = md;
        x.rd = rd; x.rdy = rdy; x.hit = hit; x.bd = bd;
        x.we = we; x.wa = wa; x.wd = wd; x.cnt = cnt;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [4:0] aa,
                         input logic [31:0] ad, input logic mv,
                         input logic [4:0] ma, input logic [31:0] md,
                         input logic [4:0] rd);
        bus.alu_valid = av;
        bus.alu_addr  = aa;
        bus.alu_data  = ad;
        bus.mem_valid = mv;
        bus.mem_addr  = ma;
        bus.mem_data  = md;
        bus.rd_addr1  = rd;
        bus.rd_addr2  = rd;
    endtask

    task automatic apply(input vec_t x, input int n);
        drive(x.av, x.aa, x.ad, x.mv, x.ma, x.md, x.rd);
        #1;
        chk($sformatf("v%0d ready", n), 32'(bus.mem_ready), 32'(x.rdy));
        chk($sformatf("v%0d hit1", n), 32'(bus.byp_hit1), 32'(x.hit));
        chk($sformatf("v%0d hit2", n), 32'(bus.byp_hit2), 32'(x.hit));
        if (x.hit) begin
            chk($sformatf("v%0d bdata1", n), bus.byp_data1, x.bd);
            chk($sformatf("v%0d bdata2", n), bus.byp_data2, x.bd);
        end
        @(posedge clk);
        #1;
        chk($sformatf("v%0d we", n), 32'(bus.write_en), 32'(x.we));
        if (x.we) begin
            chk($sformatf("v%0d waddr", n), 32'(bus.wr_addr), 32'(x.wa));
            chk($sformatf("v%0d wdata", n), bus.wr_data, x.wd);
        end
        chk($sformatf("v%0d cnt", n), 32'(bus.pending_cnt), 32'(x.cnt));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);

        // direct path and output-stage bypass
        vecs.push_back(mk(0,0,0, 1,5,32'hAAAA0001, 5,1,0,0, 1,5,32'hAAAA0001,0));
        vecs.push_back(mk(0,0,0, 0,0,0, 5,1,1,32'hAAAA0001, 0,0,0,0));
        // contention: ALU first, mem queued and bypassed from FIFO
        vecs.push_back(mk(1,3,32'h11, 1,4,32'h22, 4,1,0,0, 1,3,32'h11,1));
        vecs.push_back(mk(0,0,0, 0,0,0, 4,1,1,32'h22, 1,4,32'h22,0));
        vecs.push_back(mk(0,0,0, 0,0,0, 3,1,0,0, 0,0,0,0));
        // fill the FIFO behind four ALU writes
        for (int i = 0; i < 4; i++) begin
            vecs.push_back(mk(1,5'(10+i),32'h100+i, 1,5'(20+i),32'h200+i,
                              0,1,0,0, 1,5'(10+i),32'h100+i,i+1));
        end
        vecs.push_back(mk(1,14,32'h104, 1,24,32'h204, 21,0,1,32'h201, 1,14,32'h104,4));
        vecs.push_back(mk(0,0,0, 0,0,0, 23,0,1,32'h203, 1,20,32'h200,3));
        vecs.push_back(mk(0,0,0, 0,0,0, 0,1,0,0, 1,21,32'h201,2));
        vecs.push_back(mk(0,0,0, 0,0,0, 0,1,0,0, 1,22,32'h202,1));
        vecs.push_back(mk(0,0,0, 0,0,0, 0,1,0,0, 1,23,32'h203,0));
        // squash a queued r7 with a younger ALU r7
        vecs.push_back(mk(1,1,32'h1, 1,7,32'h70, 0,1,0,0, 1,1,32'h1,1));
        vecs.push_back(mk(1,7,32'h99, 0,0,0, 7,1,1,32'h70, 1,7,32'h99,0));
        vecs.push_back(mk(0,0,0, 0,0,0, 7,1,1,32'h99, 0,0,0,0));
        vecs.push_back(mk(0,0,0, 0,0,0, 7,1,0,0, 0,0,0,0));
        // register 0 is dropped on both paths
        vecs.push_back(mk(1,0,32'h5, 1,0,32'h6, 0,1,0,0, 0,0,0,0));
        vecs.push_back(mk(1,0,32'h5, 1,9,32'h9, 0,1,0,0, 1,9,32'h9,0));
        vecs.push_back(mk(0,0,0, 0,0,0, 9,1,1,32'h9, 0,0,0,0));
        // same-cycle mem write to the ALU's register is discarded
        vecs.push_back(mk(1,6,32'h66, 1,6,32'h67, 0,1,0,0, 1,6,32'h66,0));
        vecs.push_back(mk(0,0,0, 0,0,0, 6,1,1,32'h66, 0,0,0,0));
        vecs.push_back(mk(0,0,0, 0,0,0, 6,1,0,0, 0,0,0,0));

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst we", 32'(bus.write_en), 32'd0);
        chk("rst waddr", 32'(bus.wr_addr), 32'd0);
        chk("rst wdata", bus.wr_data, 32'd0);
        chk("rst cnt", 32'(bus.pending_cnt), 32'd0);
        chk("rst ready", 32'(bus.mem_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int n = 0; n < vecs.size(); n++) begin
            apply(vecs[n], n);
        end

        // mid-run reset with three pending entries
        for (int i = 0; i < 3; i++) begin
            drive(1, 5'(1+i), 32'(1+i), 1, 5'(11+i), 32'hB1+i, 0);
            @(posedge clk);
            #1;
        end
        chk("pre-rst cnt", 32'(bus.pending_cnt), 32'd3);
        drive(0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("mid-rst we", 32'(bus.write_en), 32'd0);
        chk("mid-rst cnt", 32'(bus.pending_cnt), 32'd0);
        chk("mid-rst ready", 32'(bus.mem_ready), 32'd0);
        chk("mid-rst waddr", 32'(bus.wr_addr), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post-rst ready", 32'(bus.mem_ready), 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("post-rst we c%0d", i), 32'(bus.write_en), 32'd0);
        end
        chk("post-rst cnt", 32'(bus.pending_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
